// File: rtl/seq_mult_param.sv
// seq_mult_param
//   Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH bits.
//   Each RUN cycle retires RADIX_BITS bits of the multiplier, so an
//   operation takes N = WIDTH/RADIX_BITS cycles. Signed operands are
//   converted to magnitudes on entry and the sign is restored at the end.
//   Valid/ready handshakes on both the operand side and the result side.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   in_valid   in   operands present on a, b, is_signed
//   in_ready   out  block can accept a new operation (IDLE)
//   a          in   multiplicand, WIDTH bits
//   b          in   multiplier, WIDTH bits
//   is_signed  in   1: two's-complement operands, 0: unsigned
//   out_valid  out  product valid (DONE)
//   out_ready  in   consumer accepts product
//   product    out  2*WIDTH-bit result, held until the next operation completes
module seq_mult_param #(
  parameter int WIDTH      = 64,
  parameter int RADIX_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int N  = WIDTH / RADIX_BITS;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic                  accept;
  logic                  last_step;
  logic [CW-1:0]         counter;
  logic                  neg;
  logic [2*WIDTH-1:0]    a_shift;
  logic [WIDTH-1:0]      b_mag;
  logic [2*WIDTH-1:0]    acc;

  logic [WIDTH-1:0]      a_mag_in;
  logic [WIDTH-1:0]      b_mag_in;
  logic [RADIX_BITS-1:0] digit;
  logic [2*WIDTH-1:0]    partial;
  logic [2*WIDTH-1:0]    acc_sum;

  // State register. Reset lands in IDLE so in_ready is high right after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs. The accept and the final RUN step are
  // decoded here so the datapath block only has to follow these strobes.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    last_step  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (counter == CW'(1)) begin
          last_step  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand magnitudes and the per-cycle partial product. The multiplicand
  // is kept pre-shifted to the current bit offset in a 2*WIDTH register, so
  // the partial is a plain small multiply by one RADIX_BITS digit. Negating
  // the most-negative value yields 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    a_mag_in = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    b_mag_in = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
    digit    = b_mag[RADIX_BITS-1:0];
    partial  = a_shift * {{(2*WIDTH-RADIX_BITS){1'b0}}, digit};
    acc_sum  = acc + partial;
  end

  // Datapath. Zero operands still run all N steps to keep latency fixed.
  // The sign is applied only on the last step, on the full-width sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_shift <= '0;
      b_mag   <= '0;
      acc     <= '0;
      neg     <= 1'b0;
      counter <= '0;
      product <= '0;
    end else if (accept) begin
      a_shift <= {{WIDTH{1'b0}}, a_mag_in};
      b_mag   <= b_mag_in;
      neg     <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      acc     <= '0;
      counter <= CW'(N);
    end else if (state == RUN) begin
      acc     <= acc_sum;
      a_shift <= a_shift << RADIX_BITS;
      b_mag   <= b_mag >> RADIX_BITS;
      counter <= counter - CW'(1);
      if (last_step) begin
        product <= neg ? (~acc_sum + 1'b1) : acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param
//   Directed bench for seq_mult_param. One instance runs at WIDTH=64,
//   RADIX_BITS=1, a second at WIDTH=16, RADIX_BITS=4. Each test task drives
//   its own vectors and compares against hand-computed products.
module tb_seq_mult_param;

  logic          clk;
  logic          rst;

  logic          in_valid64;
  logic          in_ready64;
  logic [63:0]   a64;
  logic [63:0]   b64;
  logic          s64;
  logic          out_valid64;
  logic          out_ready64;
  logic [127:0]  product64;

  logic          in_valid16;
  logic          in_ready16;
  logic [15:0]   a16;
  logic [15:0]   b16;
  logic          s16;
  logic          out_valid16;
  logic          out_ready16;
  logic [31:0]   product16;

  int pass_count;
  int check_count;

  seq_mult_param #(.WIDTH(64), .RADIX_BITS(1)) u_dut64 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid64),
    .in_ready  (in_ready64),
    .a         (a64),
    .b         (b64),
    .is_signed (s64),
    .out_valid (out_valid64),
    .out_ready (out_ready64),
    .product   (product64)
  );

  seq_mult_param #(.WIDTH(16), .RADIX_BITS(4)) u_dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .a         (a16),
    .b         (b16),
    .is_signed (s16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .product   (product16)
  );

  // Free-running 10 ns clock shared by both instances.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Waits for IDLE, then presents one operation for exactly the accept edge.
  task automatic issue64(input logic [63:0] av, input logic [63:0] bv, input logic sv);
    int guard;
    guard = 0;
    a64 = av;
    b64 = bv;
    s64 = sv;
    while (in_ready64 !== 1'b1 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    in_valid64 = 1'b1;
    @(posedge clk); #1;
    in_valid64 = 1'b0;
  endtask

  // Counts edges from the accept edge until out_valid rises (bounded).
  task automatic wait_out64(output int edges);
    edges = 0;
    while (out_valid64 !== 1'b1 && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  // One-edge result handshake.
  task automatic collect64();
    out_ready64 = 1'b1;
    @(posedge clk); #1;
    out_ready64 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_count++;
    if (in_ready64 !== 1'b1) $display("[TB] FAIL reset_in_ready64: got %b expected 1", in_ready64);
    else pass_count++;
    check_count++;
    if (out_valid64 !== 1'b0) $display("[TB] FAIL reset_out_valid64: got %b expected 0", out_valid64);
    else pass_count++;
    check_count++;
    if (product64 !== 128'h0) $display("[TB] FAIL reset_product64: got %h expected 0", product64);
    else pass_count++;
    check_count++;
    if (in_ready16 !== 1'b1 || out_valid16 !== 1'b0 || product16 !== 32'h0)
      $display("[TB] FAIL reset_dut16: got rdy=%b vld=%b prod=%h expected 1 0 0", in_ready16, out_valid16, product16);
    else pass_count++;
  endtask

  task automatic test_unsigned_max();
    int edges;
    issue64(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    wait_out64(edges);
    check_count++;
    if (edges != 64) $display("[TB] FAIL umax_latency: got %0d expected 64", edges);
    else pass_count++;
    check_count++;
    if (product64 !== 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001)
      $display("[TB] FAIL umax_product: got %h expected fffffffffffffffe0000000000000001", product64);
    else pass_count++;
    check_count++;
    if (in_ready64 !== 1'b0) $display("[TB] FAIL umax_done_in_ready: got %b expected 0", in_ready64);
    else pass_count++;
    collect64();
    check_count++;
    if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1)
      $display("[TB] FAIL umax_after_handshake: got vld=%b rdy=%b expected 0 1", out_valid64, in_ready64);
    else pass_count++;
  endtask

  task automatic test_signed();
    int edges;
    issue64(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
    wait_out64(edges);
    check_count++;
    if (product64 !== 128'h4000_0000_0000_0000_0000_0000_0000_0000)
      $display("[TB] FAIL signed_minmin: got %h expected 40000000000000000000000000000000", product64);
    else pass_count++;
    collect64();

    issue64(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    wait_out64(edges);
    check_count++;
    if (product64 !== 128'h1) $display("[TB] FAIL signed_m1m1: got %h expected 1", product64);
    else pass_count++;
    collect64();

    issue64(64'hFFFF_FFFF_FFFF_FFFE, 64'h3, 1'b1);
    wait_out64(edges);
    check_count++;
    if (edges != 64) $display("[TB] FAIL signed_latency: got %0d expected 64", edges);
    else pass_count++;
    check_count++;
    if (product64 !== 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA)
      $display("[TB] FAIL signed_m2x3: got %h expected fffffffffffffffffffffffffffffffa", product64);
    else pass_count++;
    collect64();
  endtask

  task automatic test_radix4();
    logic [15:0] av [3];
    logic [15:0] bv [3];
    logic        sv [3];
    logic [31:0] ev [3];
    int          edges;
    av[0] = 16'h1234; bv[0] = 16'h5678; sv[0] = 1'b0; ev[0] = 32'h0626_0060;
    av[1] = 16'hFFFD; bv[1] = 16'h0007; sv[1] = 1'b1; ev[1] = 32'hFFFF_FFEB;
    av[2] = 16'h0000; bv[2] = 16'hFFFF; sv[2] = 1'b0; ev[2] = 32'h0000_0000;
    for (int i = 0; i < 3; i++) begin
      a16 = av[i];
      b16 = bv[i];
      s16 = sv[i];
      in_valid16 = 1'b1;
      @(posedge clk); #1;
      in_valid16 = 1'b0;
      edges = 0;
      while (out_valid16 !== 1'b1 && edges < 50) begin
        @(posedge clk); #1;
        edges++;
      end
      check_count++;
      if (edges != 4) $display("[TB] FAIL r4_latency_%0d: got %0d expected 4", i, edges);
      else pass_count++;
      check_count++;
      if (product16 !== ev[i]) $display("[TB] FAIL r4_product_%0d: got %h expected %h", i, product16, ev[i]);
      else pass_count++;
      out_ready16 = 1'b1;
      @(posedge clk); #1;
      out_ready16 = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int edges;
    int bad;
    issue64(64'd5, 64'd7, 1'b0);
    a64 = 64'd9;
    b64 = 64'd9;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      in_valid64 = (i % 2 == 0);
      if (in_ready64 !== 1'b0 || out_valid64 !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    in_valid64 = 1'b0;
    check_count++;
    if (bad != 0) $display("[TB] FAIL bp_run_flags: got %0d bad cycles expected 0", bad);
    else pass_count++;
    wait_out64(edges);
    check_count++;
    if (edges != 34) $display("[TB] FAIL bp_latency: got %0d more edges expected 34", edges);
    else pass_count++;
    in_valid64 = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (product64 !== 128'd35 || out_valid64 !== 1'b1 || in_ready64 !== 1'b0) begin
        $display("[TB] FAIL bp_hold_%0d: got prod=%h vld=%b rdy=%b expected 35 1 0", i, product64, out_valid64, in_ready64);
        bad++;
      end
      @(posedge clk); #1;
    end
    check_count++;
    if (bad != 0) $display("[TB] FAIL bp_hold: got %0d bad cycles expected 0", bad);
    else pass_count++;
    in_valid64 = 1'b0;
    collect64();
    check_count++;
    if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1 || product64 !== 128'd35)
      $display("[TB] FAIL bp_release: got vld=%b rdy=%b prod=%h expected 0 1 35", out_valid64, in_ready64, product64);
    else pass_count++;
  endtask

  task automatic test_reset_midrun();
    int edges;
    issue64(64'd123, 64'd456, 1'b0);
    repeat (19) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_count++;
    if (out_valid64 !== 1'b0 || product64 !== 128'h0 || in_ready64 !== 1'b1)
      $display("[TB] FAIL midrun_reset: got vld=%b prod=%h rdy=%b expected 0 0 1", out_valid64, product64, in_ready64);
    else pass_count++;
    issue64(64'd3, 64'd5, 1'b0);
    wait_out64(edges);
    check_count++;
    if (edges != 64) $display("[TB] FAIL midrun_latency: got %0d expected 64", edges);
    else pass_count++;
    check_count++;
    if (product64 !== 128'd15) $display("[TB] FAIL midrun_product: got %h expected f", product64);
    else pass_count++;
    collect64();
  endtask

  task automatic test_back_to_back();
    logic [63:0]  av [3];
    logic [63:0]  bv [3];
    logic         sv [3];
    logic [127:0] ev [3];
    int           acc_cyc [3];
    int           cyc;
    int           acc_idx;
    int           res_idx;
    logic         will_accept;
    av[0] = 64'd3;                  bv[0] = 64'd5;                  sv[0] = 1'b0;
    ev[0] = 128'd15;
    av[1] = 64'hFFFF_FFFF_FFFF_FFFC; bv[1] = 64'd6;                  sv[1] = 1'b1;
    ev[1] = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFE8;
    av[2] = 64'h1_0000_0000;        bv[2] = 64'h1_0000_0000;        sv[2] = 1'b0;
    ev[2] = 128'h1_0000_0000_0000_0000;
    for (int i = 0; i < 3; i++) acc_cyc[i] = 0;
    cyc = 0;
    acc_idx = 0;
    res_idx = 0;
    a64 = av[0];
    b64 = bv[0];
    s64 = sv[0];
    in_valid64 = 1'b1;
    out_ready64 = 1'b1;
    while (res_idx < 3 && cyc < 400) begin
      will_accept = in_ready64 && in_valid64;
      if (out_valid64 === 1'b1) begin
        check_count++;
        if (product64 !== ev[res_idx])
          $display("[TB] FAIL b2b_product_%0d: got %h expected %h", res_idx, product64, ev[res_idx]);
        else pass_count++;
        res_idx++;
      end
      @(posedge clk); #1;
      cyc++;
      if (will_accept && acc_idx < 3) begin
        acc_cyc[acc_idx] = cyc;
        acc_idx++;
        if (acc_idx < 3) begin
          a64 = av[acc_idx];
          b64 = bv[acc_idx];
          s64 = sv[acc_idx];
        end else begin
          in_valid64 = 1'b0;
        end
      end
    end
    in_valid64 = 1'b0;
    out_ready64 = 1'b0;
    check_count++;
    if (res_idx != 3) $display("[TB] FAIL b2b_results: got %0d expected 3", res_idx);
    else pass_count++;
    check_count++;
    if (acc_cyc[1] - acc_cyc[0] != 66) $display("[TB] FAIL b2b_spacing_01: got %0d expected 66", acc_cyc[1] - acc_cyc[0]);
    else pass_count++;
    check_count++;
    if (acc_cyc[2] - acc_cyc[1] != 66) $display("[TB] FAIL b2b_spacing_12: got %0d expected 66", acc_cyc[2] - acc_cyc[1]);
    else pass_count++;
  endtask

  // Test sequence. Inputs start deasserted so reset is the first event.
  initial begin
    pass_count  = 0;
    check_count = 0;
    rst         = 1'b1;
    in_valid64  = 1'b0;
    out_ready64 = 1'b0;
    a64         = '0;
    b64         = '0;
    s64         = 1'b0;
    in_valid16  = 1'b0;
    out_ready16 = 1'b0;
    a16         = '0;
    b16         = '0;
    s16         = 1'b0;
    test_reset();
    test_unsigned_max();
    test_signed();
    test_radix4();
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
